// File: rtl/multiport_register_unit.sv
// multiport_register_unit: parametrised register file with READ_PORTS
// combinational read ports, one writeback port, a per-register pending
// (scoreboard) bit and a sequential clear engine for soft flush.
// Optional feature macro: REGISTER_BYPASS_EN (write-to-read forwarding).
//
// Handshake: a write (wr_en) or issue (issue_en) is accepted on a rising
// edge only when enable is high and busy is low. busy acts as "not ready":
// requests presented while busy are dropped, not held, so the producer
// must re-present them once busy falls. clear_req is sampled only in IDLE.
module multiport_register_unit #(
    parameter int SIZE       = 32,
    parameter int WIDTH      = 32,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    localparam int AW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         issue_en,
    input  logic [AW-1:0]                issue_addr,
    input  logic [READ_PORTS*AW-1:0]     rs_addr,
    output logic [READ_PORTS*WIDTH-1:0]  rs_data,
    output logic [READ_PORTS-1:0]        rs_pending,
    input  logic                         clear_req,
    output logic                         busy,
    output logic                         dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // cnt is one bit wider than an index so SIZE itself is representable.
    localparam logic [AW:0] SIZE_W = (AW + 1)'(SIZE);
    localparam logic [AW:0] LAST   = (AW + 1)'(SIZE - 1);

    logic [WIDTH-1:0] regs [0:SIZE-1];
    logic [SIZE-1:0]  pending;
    state_t           state_q, state_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             clear_start;
    logic             wr_ok;
    logic             iss_ok;

    // An index is architecturally real if it is in range and not the
    // hard-wired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < SIZE_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign busy      = (state_q == ST_CLEAR);
    assign dbg_state = state_q;
    assign wr_ok     = enable && wr_en && !busy && addr_ok(wr_addr);
    assign iss_ok    = enable && issue_en && !busy && addr_ok(issue_addr);

    // Clear FSM state and sweep counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear FSM next state: IDLE waits for clear_req, CLEAR sweeps 0..SIZE-1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clear_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    cnt_d       = '0;
                    clear_start = 1'b1;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + (AW + 1)'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register storage: the clear sweep owns the array while busy,
    // otherwise a qualified writeback commits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SIZE; i++) begin
                regs[i] <= '0;
            end
        end else if (state_q == ST_CLEAR) begin
            regs[cnt_q[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Pending bits: writeback clears, issue sets (issue last so a new
    // producer supersedes a same-edge writeback), clear start wipes all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (clear_start) begin
            pending <= '0;
        end else begin
            if (wr_ok) begin
                pending[wr_addr] <= 1'b0;
            end
            if (iss_ok) begin
                pending[issue_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports, with optional same-cycle write forwarding.
    always_comb begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;
        logic             rp;
        rs_data    = '0;
        rs_pending = '0;
        ra         = '0;
        rd         = '0;
        rp         = 1'b0;
        for (int i = 0; i < READ_PORTS; i++) begin
            ra = rs_addr[i*AW +: AW];
            rd = '0;
            rp = 1'b0;
            if (addr_ok(ra)) begin
                rd = regs[ra];
                rp = pending[ra];
            end
`ifdef REGISTER_BYPASS_EN
            if (wr_ok && (ra == wr_addr)) begin
                rd = wr_data;
                rp = iss_ok && (issue_addr == ra);
            end
`endif
            rs_data[i*WIDTH +: WIDTH] = rd;
            rs_pending[i]             = rp;
        end
    end

endmodule

// File: tb/tb_multiport_register_unit.sv
// tb_multiport_register_unit: drives two instances (SIZE=32/2 ports and
// SIZE=24/4 ports, both AW=5) from one stimulus stream and compares every
// read port and busy against an array-based reference model.
module tb_multiport_register_unit;

    localparam int AW = 5;
    localparam int W  = 32;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic              clear_req;

    logic [2*AW-1:0]   rs_addr_a;
    logic [2*W-1:0]    rs_data_a;
    logic [1:0]        rs_pend_a;
    logic              busy_a;
    logic              dbg_a;

    logic [4*AW-1:0]   rs_addr_b;
    logic [4*W-1:0]    rs_data_b;
    logic [3:0]        rs_pend_b;
    logic              busy_b;
    logic              dbg_b;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    multiport_register_unit #(
        .SIZE(32), .WIDTH(32), .READ_PORTS(2), .ZERO_REG(1)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rs_addr(rs_addr_a), .rs_data(rs_data_a), .rs_pending(rs_pend_a),
        .clear_req(clear_req), .busy(busy_a), .dbg_state(dbg_a)
    );

    multiport_register_unit #(
        .SIZE(24), .WIDTH(32), .READ_PORTS(4), .ZERO_REG(1)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rs_addr(rs_addr_b), .rs_data(rs_data_b), .rs_pending(rs_pend_b),
        .clear_req(clear_req), .busy(busy_b), .dbg_state(dbg_b)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_regs [2][32];
    bit           m_pend [2][32];
    bit           m_busy [2];
    int           m_idx  [2];
    int           m_size [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[k][i] = '0;
                m_pend[k][i] = 1'b0;
            end
            m_busy[k] = 1'b0;
            m_idx[k]  = 0;
        end
    endtask

    function automatic bit m_wr_ok(input int k);
        return enable && wr_en && !m_busy[k] && (int'(wr_addr) < m_size[k]) && (wr_addr != 5'd0);
    endfunction

    function automatic bit m_iss_ok(input int k);
        return enable && issue_en && !m_busy[k] && (int'(issue_addr) < m_size[k]) && (issue_addr != 5'd0);
    endfunction

    function automatic logic [W-1:0] exp_data(input int k, input logic [AW-1:0] a);
        if (int'(a) >= m_size[k] || a == 5'd0) return '0;
`ifdef REGISTER_BYPASS_EN
        if (m_wr_ok(k) && a == wr_addr) return wr_data;
`endif
        return m_regs[k][a];
    endfunction

    function automatic logic exp_pend(input int k, input logic [AW-1:0] a);
        if (int'(a) >= m_size[k] || a == 5'd0) return 1'b0;
`ifdef REGISTER_BYPASS_EN
        if (m_wr_ok(k) && a == wr_addr) return m_iss_ok(k) && (issue_addr == a);
`endif
        return m_pend[k][a];
    endfunction

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit wok;
            bit iok;
            wok = m_wr_ok(k);
            iok = m_iss_ok(k);
            if (m_busy[k]) begin
                m_regs[k][m_idx[k]] = '0;
                m_idx[k]++;
                if (m_idx[k] == m_size[k]) m_busy[k] = 1'b0;
            end else begin
                if (wok) m_regs[k][wr_addr] = wr_data;
                if (clear_req) begin
                    for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
                    m_busy[k] = 1'b1;
                    m_idx[k]  = 0;
                end else begin
                    if (wok) m_pend[k][wr_addr] = 1'b0;
                    if (iok) m_pend[k][issue_addr] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- driver helpers ----------------
    function automatic logic [AW-1:0] port_addr(input int k, input int p);
        return (k == 0) ? rs_addr_a[p*AW +: AW] : rs_addr_b[p*AW +: AW];
    endfunction

    function automatic logic [W-1:0] port_data(input int k, input int p);
        return (k == 0) ? rs_data_a[p*W +: W] : rs_data_b[p*W +: W];
    endfunction

    function automatic logic port_pend(input int k, input int p);
        return (k == 0) ? rs_pend_a[p] : rs_pend_b[p];
    endfunction

    task automatic set_port(input int k, input int p, input logic [AW-1:0] a);
        if (k == 0) rs_addr_a[p*AW +: AW] = a;
        else        rs_addr_b[p*AW +: AW] = a;
    endtask

    task automatic idle();
        enable    = 1'b1;
        wr_en     = 1'b0;
        issue_en  = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int np;
            np = (k == 0) ? 2 : 4;
            for (int p = 0; p < np; p++) begin
                check($sformatf("dut%0d_p%0d_data", k, p), port_data(k, p), exp_data(k, port_addr(k, p)));
                check($sformatf("dut%0d_p%0d_pend", k, p), {31'b0, port_pend(k, p)},
                      {31'b0, exp_pend(k, port_addr(k, p))});
            end
        end
        check("dut0_busy", {31'b0, busy_a}, {31'b0, m_busy[0]});
        check("dut1_busy", {31'b0, busy_b}, {31'b0, m_busy[1]});
    endtask

    // Inputs are set just after a falling edge; check, take the rising edge,
    // update the model, return at the next falling edge.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic fill_index();
        for (int i = 1; i < 32; i++) begin
            write(i[AW-1:0], i);
            step();
        end
        idle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int na;
        int nb;
        m_size[0] = 32;
        m_size[1] = 24;
        reset      = 1'b0;
        idle();
        wr_addr    = '0;
        wr_data    = '0;
        issue_addr = '0;
        rs_addr_a  = '0;
        rs_addr_b  = '0;
        model_reset();
        set_port(0, 0, 5'd5);
        set_port(0, 1, 5'd9);
        set_port(1, 2, 5'd17);
        repeat (2) @(negedge clk);
        #1;
        compare_all();
        check("reset_busy", {31'b0, busy_a}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Write x5, visible next cycle (or same cycle with forwarding).
        write(5'd5, 32'hDEADBEEF);
        set_port(0, 0, 5'd5);
        set_port(1, 0, 5'd5);
        #1;
`ifdef REGISTER_BYPASS_EN
        check("t1_same_cycle", rs_data_a[31:0], 32'hDEADBEEF);
`else
        check("t1_same_cycle", rs_data_a[31:0], 32'h0);
`endif
        step();
        idle();
        #1;
        check("t1_next_cycle", rs_data_a[31:0], 32'hDEADBEEF);
        step();

        // Zero register: write and issue both ignored.
        write(5'd0, 32'h1234);
        issue_en   = 1'b1;
        issue_addr = 5'd0;
        step();
        idle();
        for (int p = 0; p < 4; p++) set_port(1, p, 5'd0);
        set_port(0, 0, 5'd0);
        set_port(0, 1, 5'd0);
        #1;
        check("t2_x0_data", rs_data_a[31:0], 32'h0);
        check("t2_x0_pend_a", {30'b0, rs_pend_a}, 32'h0);
        check("t2_x0_pend_b", {28'b0, rs_pend_b}, 32'h0);
        step();

        // Pending lifecycle on x7.
        set_port(0, 0, 5'd7);
        set_port(1, 0, 5'd7);
        issue_en   = 1'b1;
        issue_addr = 5'd7;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_pend_held", {31'b0, rs_pend_a[0]}, 32'd1);
            step();
        end
        write(5'd7, 32'h55);
        step();
        idle();
        #1;
        check("t3_pend_cleared", {31'b0, rs_pend_a[0]}, 32'd0);
        check("t3_data", rs_data_a[31:0], 32'h55);
        step();
        write(5'd7, 32'h66);
        issue_en   = 1'b1;
        issue_addr = 5'd7;
        step();
        idle();
        #1;
        check("t3_set_wins", {31'b0, rs_pend_a[0]}, 32'd1);
        check("t3_data2", rs_data_a[31:0], 32'h66);
        step();

        // Full clear sweep; a write while busy is dropped.
        fill_index();
        set_port(0, 0, 5'd3);
        set_port(0, 1, 5'd20);
        set_port(1, 0, 5'd3);
        set_port(1, 1, 5'd23);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        na = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            if (i == 5) write(5'd9, 32'hFFFF);
            else        wr_en = 1'b0;
            step();
        end
        check("t4_busy_cycles_a", na, 32);
        check("t4_busy_cycles_b", nb, 24);
        for (int a = 0; a < 32; a++) begin
            set_port(0, 0, a[AW-1:0]);
            set_port(1, 0, a[AW-1:0]);
            #1;
            check("t4_cleared_a", rs_data_a[31:0], 32'h0);
            check("t4_cleared_b", rs_data_b[31:0], 32'h0);
            step();
        end

        // Reset in the middle of a clear sweep.
        fill_index();
        set_port(0, 0, 5'd20);
        set_port(1, 0, 5'd20);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (10) step();
        reset = 1'b0;
        #1;
        check("t5_busy_a", {31'b0, busy_a}, 32'd0);
        check("t5_busy_b", {31'b0, busy_b}, 32'd0);
        check("t5_x20", rs_data_a[31:0], 32'h0);
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // Out-of-range index on the 24-entry instance.
        write(5'd25, 32'hABCD);
        step();
        idle();
        set_port(1, 0, 5'd25);
        #1;
        check("t6_x25_b", rs_data_b[31:0], 32'h0);
        step();
        for (int p = 0; p < 4; p++) begin
            write(5'(p + 10), 32'h100 + p);
            step();
        end
        idle();
        for (int p = 0; p < 4; p++) set_port(1, p, 5'(p + 10));
        #1;
        for (int p = 0; p < 4; p++) begin
            check("t6_four_ports", rs_data_b[p*W +: W], 32'h100 + p);
        end
        step();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            enable     = ($urandom_range(0, 9) != 0);
            wr_en      = $urandom_range(0, 1);
            wr_addr    = 5'($urandom_range(0, 31));
            wr_data    = $urandom;
            issue_en   = $urandom_range(0, 1);
            issue_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            clear_req  = ($urandom_range(0, 79) == 0);
            for (int p = 0; p < 2; p++)
                set_port(0, p, ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31)));
            for (int p = 0; p < 4; p++)
                set_port(1, p, ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiport_register_unit.md
Name: multiport_register_unit

Overview:
Parametrised general-purpose register file, successor to the single-write, two-read register unit of the core. Generalises register width, register count and number of read ports. Adds a per-register pending (scoreboard) bit for multi-cycle producers and a sequential clear engine for soft flush without reset. Sits between decode (read addresses, issue) and writeback (write port).

Parameters:
SIZE, 32, number of registers; AW = $clog2(SIZE), minimum 1
WIDTH, 32, register width in bits
READ_PORTS, 2, number of independent read ports, 1..4
ZERO_REG, 1, when 1 register 0 is hard-wired to zero and never pending

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  qualifies write and issue; low freezes them
wr_en  input  1  writeback request
wr_addr  input  AW  writeback register index
wr_data  input  WIDTH  writeback value
issue_en  input  1  mark wr destination of a newly issued instruction pending
issue_addr  input  AW  register to mark pending
rs_addr  input  READ_PORTS*AW  packed read indices, port i at [i*AW +: AW]
rs_data  output  READ_PORTS*WIDTH  packed read data
rs_pending  output  READ_PORTS  pending bit of each addressed register
clear_req  input  1  start sequential clear
busy  output  1  clear engine active

Behaviour:
- Reset (reset=0, async): all registers 0, all pending bits 0, FSM IDLE, busy=0; rs_data reads 0 and rs_pending reads 0 for every port.
- Write commits at posedge when enable && wr_en && !busy && wr_addr<SIZE && !(ZERO_REG && wr_addr==0). Otherwise ignored.
- Reads are combinational. rs_data port i = x[rs_addr_i]; returns 0 if rs_addr_i>=SIZE, or if ZERO_REG and the index is 0.
- Write-to-read latency without the bypass feature: one cycle (new value visible after the commit edge).
- Pending bits: a committed write clears pending[wr_addr]. When enable && issue_en && !busy, pending[issue_addr] is set at posedge.
- Same-edge issue and write to the same index: set wins (a new producer supersedes).
- Issue to index 0 with ZERO_REG=1, or to any index >=SIZE, is ignored.
- Clear FSM, IDLE: clear_req=1 -> CLEAR at next edge. At that edge all pending bits go to 0 and cnt:=0.
- Clear FSM, CLEAR: busy=1. Each cycle x[cnt]:=0 and cnt++. After zeroing SIZE-1 -> IDLE; busy drops on that edge.
- Clear duration: exactly SIZE cycles with busy=1.
- The clear engine ignores enable. clear_req while busy is ignored. wr_en and issue_en are dropped while busy.
- Reads during CLEAR return current contents: partially cleared is legal.
- Same-edge clear_req and write in IDLE: the write commits, then the clear proceeds.
- reset asserted mid-clear: immediate return to IDLE, all state zeroed.
- Width rules: cnt is AW+1 bits so it cannot wrap on power-of-two SIZE. No arithmetic on data.

Optional Feature:
REGISTER_BYPASS_EN.
- Defined: when a write qualifies this cycle and rs_addr_i==wr_addr (and the index is not the zero register), rs_data port i = wr_data combinationally. rs_pending_i reads 0 in the same cycle unless an issue to the same index also occurs that cycle.
- Undefined: no forwarding; one-cycle write-to-read latency as above.

Test Plan:
1. Release reset, write x5=0xDEADBEEF, read port0=5 next cycle -> 0xDEADBEEF. With bypass: read on write cycle -> 0xDEADBEEF; without bypass -> 0x0.
2. Write x0=0x1234 with ZERO_REG=1; issue x0 -> read x0=0, rs_pending=0 on all ports.
3. Issue x7, then 3 cycles later write x7=0x55 -> rs_pending for x7 is 1 for 3 cycles, then 0. Same-edge issue+write x7 -> stays 1.
4. Fill x1..x31 with index value, pulse clear_req -> busy=1 for exactly 32 cycles. x3 reads 3 until the edge cnt=3 commits, then 0. All registers 0 at the end; a write during busy is dropped.
5. Assert reset mid-clear at cnt=10 -> busy=0 immediately; x20 (previously 20) reads 0.
6. READ_PORTS=4, SIZE=24: read x25 -> 0; write x25 ignored. Four ports read distinct registers concurrently with correct data.
